// File: rtl/mem_port_arb_if.sv
// Bus bundle for the shared memory port arbiter: fetch port, data port and memory handshake.
// The arbiter uses the slave view; the CPU/memory side (or a bench) uses the master view.
interface mem_port_arb_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;

  logic          err;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_rdy,
    output if_done, if_rdata, dm_done, dm_rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_rdy,
    input  if_done, if_rdata, dm_done, dm_rdata, err, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arb.sv
// Shares one single-port memory between instruction fetch and data access, with
// round-robin arbitration, registered read data, one-cycle DONE pulses and a per-access timeout.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | no access outstanding; arbitrate eligible requesters
//  BUSY_IF | fetch read in flight, waiting for mem_rdy or timeout
//  BUSY_DM | data load/store in flight, waiting for mem_rdy or timeout
module mem_port_arb #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input logic           CLK,
  input logic           RST_F,
  mem_port_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } state_t;

  localparam logic [7:0] COUNT_LAST = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic          last_dm, last_dm_nxt;
  logic [7:0]    count, count_nxt;

  logic          mem_req, mem_req_nxt;
  logic          mem_we, mem_we_nxt;
  logic [AW-1:0] mem_addr, mem_addr_nxt;
  logic [DW-1:0] mem_wdata, mem_wdata_nxt;
  logic          if_done, if_done_nxt;
  logic [DW-1:0] if_rdata, if_rdata_nxt;
  logic          dm_done, dm_done_nxt;
  logic [DW-1:0] dm_rdata, dm_rdata_nxt;
  logic          err, err_nxt;

  logic          if_elig;
  logic          dm_elig;
  logic          grant_if;
  logic          grant_dm;

  // A requester whose DONE is showing this cycle still has its old REQ up; skip it once.
  assign if_elig  = bus.if_req & ~if_done;
  assign dm_elig  = bus.dm_req & ~dm_done;
  assign grant_if = if_elig & (~dm_elig | last_dm);
  assign grant_dm = dm_elig & ~grant_if;

  always_ff @(posedge CLK or negedge RST_F) begin
    if (!RST_F) begin
      state     <= IDLE;
      last_dm   <= 1'b1;
      count     <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_done   <= 1'b0;
      if_rdata  <= '0;
      dm_done   <= 1'b0;
      dm_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_dm   <= last_dm_nxt;
      count     <= count_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      if_done   <= if_done_nxt;
      if_rdata  <= if_rdata_nxt;
      dm_done   <= dm_done_nxt;
      dm_rdata  <= dm_rdata_nxt;
      err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    last_dm_nxt   = last_dm;
    count_nxt     = count;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    if_rdata_nxt  = if_rdata;
    dm_rdata_nxt  = dm_rdata;
    if_done_nxt   = 1'b0;
    dm_done_nxt   = 1'b0;
    err_nxt       = 1'b0;

    case (state)
      IDLE: begin
        mem_req_nxt = 1'b0;
        if (grant_if) begin
          mem_req_nxt  = 1'b1;
          mem_we_nxt   = 1'b0;
          mem_addr_nxt = bus.if_addr;
          count_nxt    = 8'd0;
          last_dm_nxt  = 1'b0;
          state_nxt    = BUSY_IF;
        end else if (grant_dm) begin
          mem_req_nxt   = 1'b1;
          mem_we_nxt    = bus.dm_we;
          mem_addr_nxt  = bus.dm_addr;
          mem_wdata_nxt = bus.dm_wdata;
          count_nxt     = 8'd0;
          last_dm_nxt   = 1'b1;
          state_nxt     = BUSY_DM;
        end
      end

      BUSY_IF, BUSY_DM: begin
        // A ready on the timeout edge still counts as a normal completion.
        if (bus.mem_rdy) begin
          if (state == BUSY_IF) begin
            if_done_nxt  = 1'b1;
            if_rdata_nxt = bus.mem_rdata;
          end else begin
            dm_done_nxt = 1'b1;
            if (!mem_we) dm_rdata_nxt = bus.mem_rdata;
          end
          mem_req_nxt = 1'b0;
          state_nxt   = IDLE;
        end else if (count == COUNT_LAST) begin
          if (state == BUSY_IF) if_done_nxt = 1'b1;
          else                  dm_done_nxt = 1'b1;
          err_nxt     = 1'b1;
          mem_req_nxt = 1'b0;
          state_nxt   = IDLE;
        end else begin
          count_nxt = count + 8'd1;
        end
      end

      default: begin
        mem_req_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.if_done   = if_done;
  assign bus.if_rdata  = if_rdata;
  assign bus.dm_done   = dm_done;
  assign bus.dm_rdata  = dm_rdata;
  assign bus.err       = err;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: directed scenarios plus randomized traffic scored against a
// transaction-level model (round-robin owner choice, memory array, latency-to-done rule).
module tb_mem_port_arb;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int TIMEOUT = 15;

  logic CLK = 1'b0;
  logic RST_F;
  always #5 CLK = ~CLK;

  mem_port_arb_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arb #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .CLK  (CLK),
    .RST_F(RST_F),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem_model [256];
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_dm_rdata;
  int last_srv;        // 1 = fetch served last, 2 = data served last
  int grants[$];

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST_F = 1'b0;
    #12;
    checks++;
    if ({bus.if_done, bus.if_rdata, bus.dm_done, bus.dm_rdata, bus.err, bus.mem_req,
         bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b done=%b/%b err=%b exp all zero",
               bus.mem_req, bus.if_done, bus.dm_done, bus.err);
    end
    @(negedge CLK);
    RST_F = 1'b1;
    step();
    bus.dm_req  = 1'b1;
    bus.dm_addr = 8'h33;
    step();
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_grant mem_req got %b exp 1", bus.mem_req);
    end
    step();
    step();
    RST_F = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.dm_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_access got req=%b done=%b exp 0 0", bus.mem_req, bus.dm_done);
    end
    bus.dm_req  = 1'b0;
    bus.mem_rdy = 1'b1;
    step();
    step();
    checks++;
    if (bus.dm_done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got done=%b err=%b exp 0 0", bus.dm_done, bus.err);
    end
    bus.mem_rdy = 1'b0;
    @(negedge CLK);
    RST_F = 1'b1;
    step();
    checks++;
    if ({bus.if_done, bus.if_rdata, bus.dm_done, bus.dm_rdata, bus.err, bus.mem_req,
         bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_release got req=%b addr=%h we=%b exp all zero",
               bus.mem_req, bus.mem_addr, bus.mem_we);
    end
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    last_srv     = 2;
  endtask

  // Transaction-level traffic engine: random requesters, random memory latency.
  task automatic run_traffic(input int n_if, input int n_dm, input int raise_pct,
                             input bit hold, input int drop_pct, input int lat_max,
                             input int budget);
    int rem_if, rem_dm, owner, elapsed, lat, exp_el, exp_own, cyc;
    bit want_if, want_dm, exp_err, e_if_req, e_dm_req, p_if_done, p_dm_done;
    bit el_if, el_dm, done_if_now, done_dm_now;
    logic [AW-1:0] a_if, a_dm;
    logic          a_we;
    logic [DW-1:0] a_wd, rd_val;
    rem_if = n_if; rem_dm = n_dm; owner = 0; elapsed = 0; lat = 0; exp_el = 0; cyc = 0;
    want_if = 0; want_dm = 0; exp_err = 0; e_if_req = 0; e_dm_req = 0;
    p_if_done = 0; p_dm_done = 0;
    a_if = '0; a_dm = '0; a_we = 0; a_wd = '0; rd_val = '0;
    while ((rem_if > 0 || rem_dm > 0 || want_if || want_dm || owner != 0) && cyc < budget) begin
      step();
      cyc++;
      done_if_now = 0;
      done_dm_now = 0;
      if (owner == 0) begin
        el_if = e_if_req && !p_if_done;
        el_dm = e_dm_req && !p_dm_done;
        exp_own = 0;
        if (el_if && el_dm) exp_own = (last_srv == 1) ? 2 : 1;
        else if (el_if)     exp_own = 1;
        else if (el_dm)     exp_own = 2;
        checks++;
        if (bus.mem_req !== (exp_own != 0) || bus.if_done !== 1'b0 ||
            bus.dm_done !== 1'b0 || bus.err !== 1'b0) begin
          errors++;
          $display("FAIL idle_grant got req=%b done=%b/%b err=%b exp req=%0d", bus.mem_req,
                   bus.if_done, bus.dm_done, bus.err, exp_own != 0);
        end
        if (exp_own != 0 && bus.mem_req === 1'b1) begin
          checks++;
          if ({bus.mem_we, bus.mem_addr} !== ((exp_own == 1) ? {1'b0, a_if} : {a_we, a_dm})) begin
            errors++;
            $display("FAIL grant_cmd owner=%0d got we=%b addr=%h exp fetch=%h data=%b/%h",
                     exp_own, bus.mem_we, bus.mem_addr, a_if, a_we, a_dm);
          end
          if (exp_own == 2 && a_we) begin
            checks++;
            if (bus.mem_wdata !== a_wd) begin
              errors++;
              $display("FAIL grant_wdata got %h exp %h", bus.mem_wdata, a_wd);
            end
          end
          owner    = exp_own;
          last_srv = exp_own;
          grants.push_back(exp_own);
          elapsed  = 0;
          lat      = $urandom_range(lat_max, 0);
          exp_err  = (lat >= TIMEOUT);
          exp_el   = exp_err ? TIMEOUT : lat + 1;
        end
      end else begin
        elapsed++;
        if (elapsed == exp_el) begin
          if (!exp_err) begin
            if (owner == 1) exp_if_rdata = rd_val;
            else if (!a_we) exp_dm_rdata = rd_val;
            else mem_model[a_dm] = a_wd;
          end
          checks++;
          if ({bus.if_done, bus.dm_done, bus.err, bus.mem_req} !==
              {owner == 1, owner == 2, exp_err, 1'b0}) begin
            errors++;
            $display("FAIL done_pulse owner=%0d got done=%b/%b err=%b req=%b exp err=%b",
                     owner, bus.if_done, bus.dm_done, bus.err, bus.mem_req, exp_err);
          end
          checks++;
          if (bus.if_rdata !== exp_if_rdata || bus.dm_rdata !== exp_dm_rdata) begin
            errors++;
            $display("FAIL done_rdata got if=%h dm=%h exp if=%h dm=%h", bus.if_rdata,
                     bus.dm_rdata, exp_if_rdata, exp_dm_rdata);
          end
          done_if_now = (owner == 1);
          done_dm_now = (owner == 2);
          owner = 0;
        end else begin
          checks++;
          if ({bus.if_done, bus.dm_done, bus.err, bus.mem_req} !== 4'b0001) begin
            errors++;
            $display("FAIL busy_hold got done=%b/%b err=%b req=%b exp 0 0 0 1",
                     bus.if_done, bus.dm_done, bus.err, bus.mem_req);
          end
        end
      end
      // memory responder; ready while idle is noise the arbiter must ignore
      if (owner != 0 && elapsed == lat) begin
        rd_val        = (owner == 1) ? mem_model[a_if] : mem_model[a_dm];
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = (owner == 2 && a_we) ? DW'($urandom) : rd_val;
      end else begin
        bus.mem_rdy   = (owner == 0 && $urandom_range(3, 0) == 0);
        bus.mem_rdata = DW'($urandom);
      end
      if (done_if_now) begin
        want_if = 0;
        bus.if_req = 1'b0;
        if (hold && rem_if > 0) begin
          rem_if--; want_if = 1; a_if = AW'($urandom);
          bus.if_req = 1'b1; bus.if_addr = a_if;
        end
      end else if (!want_if && rem_if > 0 && $urandom_range(99, 0) < raise_pct) begin
        rem_if--; want_if = 1; a_if = AW'($urandom);
        bus.if_req = 1'b1; bus.if_addr = a_if;
      end else if (want_if && owner == 1 && $urandom_range(99, 0) < drop_pct) begin
        bus.if_req = 1'b0;
      end
      if (done_dm_now) begin
        want_dm = 0;
        bus.dm_req = 1'b0;
        if (hold && rem_dm > 0) begin
          rem_dm--; want_dm = 1; a_dm = AW'($urandom); a_we = 1'($urandom); a_wd = DW'($urandom);
          bus.dm_req = 1'b1; bus.dm_addr = a_dm; bus.dm_we = a_we; bus.dm_wdata = a_wd;
        end
      end else if (!want_dm && rem_dm > 0 && $urandom_range(99, 0) < raise_pct) begin
        rem_dm--; want_dm = 1; a_dm = AW'($urandom); a_we = 1'($urandom); a_wd = DW'($urandom);
        bus.dm_req = 1'b1; bus.dm_addr = a_dm; bus.dm_we = a_we; bus.dm_wdata = a_wd;
      end else if (want_dm && owner == 2 && $urandom_range(99, 0) < drop_pct) begin
        bus.dm_req = 1'b0;
      end
      e_if_req  = bus.if_req;
      e_dm_req  = bus.dm_req;
      p_if_done = done_if_now;
      p_dm_done = done_dm_now;
    end
    checks++;
    if (cyc >= budget) begin
      errors++;
      $display("FAIL traffic_budget got %0d cycles exp under %0d", cyc, budget);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_round_robin();
    grants.delete();
    run_traffic(3, 3, 100, 1'b1, 0, 6, 400);
    checks++;
    if (grants.size() != 6) begin
      errors++;
      $display("FAIL rr_count got %0d exp 6", grants.size());
    end
    for (int i = 0; i < grants.size() && i < 6; i++) begin
      checks++;
      if (grants[i] != ((i % 2 == 0) ? 1 : 2)) begin
        errors++;
        $display("FAIL rr_order idx %0d got %0d exp %0d", i, grants[i], (i % 2 == 0) ? 1 : 2);
      end
    end
  endtask

  task automatic test_if_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h10;
    step();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 8'h10}) begin
      errors++;
      $display("FAIL fetch_cmd got req=%b we=%b addr=%h exp 1 0 10", bus.mem_req, bus.mem_we,
               bus.mem_addr);
    end
    step();
    step();
    bus.mem_rdy   = 1'b1;
    bus.mem_rdata = 32'hA5A5_0001;
    step();
    exp_if_rdata = 32'hA5A5_0001;
    checks++;
    if ({bus.if_done, bus.err, bus.mem_req} !== 3'b100 || bus.if_rdata !== exp_if_rdata) begin
      errors++;
      $display("FAIL fetch_done got done=%b err=%b req=%b data=%h exp 1 0 0 %h", bus.if_done,
               bus.err, bus.mem_req, bus.if_rdata, exp_if_rdata);
    end
    bus.mem_rdy = 1'b0;
    bus.if_req  = 1'b0;
    step();
    checks++;
    if (bus.if_done !== 1'b0) begin
      errors++;
      $display("FAIL fetch_pulse got %b exp 0", bus.if_done);
    end
    last_srv = 1;
  endtask

  task automatic test_store();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 8'h20;
    bus.dm_wdata = 32'h1234_5678;
    step();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !==
        {1'b1, 1'b1, 8'h20, 32'h1234_5678}) begin
      errors++;
      $display("FAIL store_cmd got we=%b addr=%h wdata=%h exp 1 20 12345678", bus.mem_we,
               bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_rdy   = 1'b1;
    bus.mem_rdata = 32'hDEAD_BEEF;
    step();
    checks++;
    if ({bus.dm_done, bus.err, bus.mem_req} !== 3'b100 || bus.dm_rdata !== exp_dm_rdata) begin
      errors++;
      $display("FAIL store_done got done=%b err=%b rdata=%h exp 1 0 %h", bus.dm_done, bus.err,
               bus.dm_rdata, exp_dm_rdata);
    end
    mem_model[8'h20] = 32'h1234_5678;
    idle_inputs();
    step();
    last_srv = 2;
  endtask

  task automatic test_timeout_edge();
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h55;
    step();
    checks++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 8'h55}) begin
      errors++;
      $display("FAIL edge_cmd got req=%b we=%b addr=%h exp 1 0 55", bus.mem_req, bus.mem_we,
               bus.mem_addr);
    end
    repeat (TIMEOUT - 1) step();
    checks++;
    if (bus.if_done !== 1'b0 || bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL edge_early got done=%b req=%b exp 0 1", bus.if_done, bus.mem_req);
    end
    bus.mem_rdy   = 1'b1;
    bus.mem_rdata = 32'hC0DE_0015;
    step();
    exp_if_rdata = 32'hC0DE_0015;
    checks++;
    if ({bus.if_done, bus.err, bus.mem_req} !== 3'b100 || bus.if_rdata !== exp_if_rdata) begin
      errors++;
      $display("FAIL edge_done got done=%b err=%b req=%b data=%h exp 1 0 0 %h", bus.if_done,
               bus.err, bus.mem_req, bus.if_rdata, exp_if_rdata);
    end
    idle_inputs();
    step();
    last_srv = 1;
  endtask

  task automatic test_timeout();
    int  n;
    bit  seen;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 8'h44;
    step();
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      bus.mem_rdata = DW'($urandom);
      step();
      n++;
      if (bus.dm_done === 1'b1 || bus.err === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || n != TIMEOUT) begin
      errors++;
      $display("FAIL timeout_latency got %0d cycles seen=%b exp %0d", n, seen, TIMEOUT);
    end
    checks++;
    if ({bus.dm_done, bus.err, bus.mem_req} !== 3'b110 || bus.dm_rdata !== exp_dm_rdata) begin
      errors++;
      $display("FAIL timeout_done got done=%b err=%b req=%b rdata=%h exp 1 1 0 %h", bus.dm_done,
               bus.err, bus.mem_req, bus.dm_rdata, exp_dm_rdata);
    end
    idle_inputs();
    step();
    checks++;
    if (bus.dm_done !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_pulse got done=%b err=%b exp 0 0", bus.dm_done, bus.err);
    end
    last_srv = 2;
  endtask

  task automatic test_random();
    run_traffic(40, 40, 30, 1'b0, 15, 18, 20000);
    run_traffic(20, 20, 60, 1'b1, 0, 16, 8000);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = DW'($urandom);
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    last_srv = 2;
    test_reset();
    test_round_robin();
    test_if_fetch();
    test_store();
    test_timeout_edge();
    test_timeout();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
